// File: rtl/modport_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge: FSM states, AHB
// transfer encodings, the bridge address window and the APB slave map.
package modport_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_READ,
    ST_WRITE,
    ST_WRITEP,
    ST_RENABLE,
    ST_WENABLE,
    ST_WENABLEP
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [1:0] HRESP_OKAY = 2'b00;

  localparam logic [31:0] ADDR_LO   = 32'h8000_0000;
  localparam logic [31:0] ADDR_HI   = 32'h8BFF_FFFF;
  localparam logic [31:0] SLV0_BASE = 32'h8000_0000;
  localparam logic [31:0] SLV1_BASE = 32'h8400_0000;
  localparam logic [31:0] SLV2_BASE = 32'h8800_0000;

  // One address stage of the AHB pipeline.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
  } stage_t;

  // Only addresses inside the bridge window ever reach this decoder.
  function automatic logic [2:0] decode_sel(input logic [31:0] addr);
    logic [2:0] sel;
    sel = 3'b000;
    if (addr >= SLV2_BASE)      sel = 3'b100;
    else if (addr >= SLV1_BASE) sel = 3'b010;
    else if (addr >= SLV0_BASE) sel = 3'b001;
    return sel;
  endfunction

endpackage

// File: rtl/modport_bridge_ahb_slave_if.sv
// AHB slave side of the bridge: transfer validity, the two-stage address
// pipeline (current and pending), write-data capture and slave decode.
module ahb_slave_if
  import modport_bridge_pkg::*;
(
  input  logic        clock,
  input  logic        Hresetn,
  input  logic [1:0]  Htrans,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic        load_cur_i,
  input  logic        load_pend_i,
  input  logic        promote_i,
  input  logic        wdata_en_i,
  output logic        valid_o,
  output stage_t      cur_o,
  output logic        pend_write_o,
  output logic [31:0] wdata_o,
  output logic [2:0]  sel_o
);

  stage_t      cur_q,   cur_d;
  stage_t      pend_q,  pend_d;
  logic [31:0] wdata_q, wdata_d;
  stage_t      incoming;

  assign valid_o = Hreadyin
                && (Htrans == HTRANS_NONSEQ || Htrans == HTRANS_SEQ)
                && (Haddr >= ADDR_LO) && (Haddr <= ADDR_HI);

  assign incoming = '{addr: Haddr, write: Hwrite};

  // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
  always_comb begin
    cur_d   = cur_q;
    pend_d  = pend_q;
    wdata_d = wdata_q;
    // Promotion wins: in WENABLEP the pending stage moves up while a new
    // transfer may refill the pending slot in the same edge.
    if (promote_i)       cur_d = pend_q;
    else if (load_cur_i) cur_d = incoming;
    if (load_pend_i)     pend_d = incoming;
    if (wdata_en_i)      wdata_d = Hwdata;
  end

  // NOTE: pipeline registers are reset so an aborted transfer leaves no trace
  // behind, and state is updated with non-blocking assignments only.
  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      cur_q   <= '0;
      pend_q  <= '0;
      wdata_q <= '0;
    end else begin
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      wdata_q <= wdata_d;
    end
  end

  assign cur_o        = cur_q;
  assign pend_write_o = pend_q.write;
  assign wdata_o      = wdata_q;
  assign sel_o        = decode_sel(cur_q.addr);

endmodule

// File: rtl/modport_bridge.sv
// AHB-to-APB bridge top: bridge FSM and APB drive around the AHB slave
// interface. Every APB access is a fixed two-cycle setup/enable pair.
module modport_bridge
  import modport_bridge_pkg::*;
(
  input  logic        clock,
  input  logic        Hresetn,
  input  logic [1:0]  Htrans,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [2:0]  Hsize,
  input  logic [2:0]  Hbrust,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Hrdata,
  input  logic [31:0] Prdata,
  output logic [2:0]  Pselx,
  output logic        Penable,
  output logic        Pwrite,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata
);

  state_e      state_q, state_d;
  logic        valid;
  stage_t      cur;
  logic        pend_write;
  logic [31:0] wdata;
  logic [2:0]  sel;
  logic        load_cur, load_pend, promote, wdata_en;
  logic        unused_ok;

  assign unused_ok = ^{Hsize, Hbrust};

  ahb_slave_if u_ahb_if (
    .clock        (clock),
    .Hresetn      (Hresetn),
    .Htrans       (Htrans),
    .Hwrite       (Hwrite),
    .Hreadyin     (Hreadyin),
    .Haddr        (Haddr),
    .Hwdata       (Hwdata),
    .load_cur_i   (load_cur),
    .load_pend_i  (load_pend),
    .promote_i    (promote),
    .wdata_en_i   (wdata_en),
    .valid_o      (valid),
    .cur_o        (cur),
    .pend_write_o (pend_write),
    .wdata_o      (wdata),
    .sel_o        (sel)
  );

  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Transfers are only accepted in states that drive Hreadyout high.
  always_comb begin
    state_d   = state_q;
    Hreadyout = 1'b1;
    load_cur  = 1'b0;
    load_pend = 1'b0;
    promote   = 1'b0;
    wdata_en  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        load_cur = valid;
        if (valid) state_d = Hwrite ? ST_WWAIT : ST_READ;
        else       state_d = ST_IDLE;
      end
      ST_WWAIT: begin
        wdata_en  = 1'b1;
        load_pend = valid;
        state_d   = valid ? ST_WRITEP : ST_WRITE;
      end
      ST_READ: begin
        Hreadyout = 1'b0;
        state_d   = ST_RENABLE;
      end
      ST_WRITE: begin
        Hreadyout = 1'b0;
        state_d   = ST_WENABLE;
      end
      ST_WRITEP: begin
        Hreadyout = 1'b0;
        state_d   = ST_WENABLEP;
      end
      ST_WENABLEP: begin
        promote = 1'b1;
        if (pend_write) begin
          wdata_en  = 1'b1;
          load_pend = valid;
          state_d   = valid ? ST_WRITEP : ST_WRITE;
        end else begin
          Hreadyout = 1'b0;
          state_d   = ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Pselx   = 3'b000;
    Penable = 1'b0;
    Pwrite  = 1'b0;
    Paddr   = '0;
    Pwdata  = '0;
    Hrdata  = '0;
    unique case (state_q)
      ST_READ, ST_WRITE, ST_WRITEP,
      ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
        Pselx   = sel;
        Paddr   = cur.addr;
        Pwrite  = cur.write;
        Pwdata  = wdata;
        Penable = (state_q == ST_RENABLE) || (state_q == ST_WENABLE)
               || (state_q == ST_WENABLEP);
        if (state_q == ST_RENABLE) Hrdata = Prdata;
      end
      default: ;
    endcase
  end

  assign Hresp = HRESP_OKAY;

endmodule

// File: tb/tb_modport_bridge.sv
// Directed bench for modport_bridge: reset, single write/read, back-to-back
// writes, invalid transfers, address boundaries and write-then-read.
module tb_modport_bridge;
  import modport_bridge_pkg::*;

  logic        clock;
  logic        Hresetn;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic        Hreadyin;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [2:0]  Hsize;
  logic [2:0]  Hbrust;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  logic [31:0] Prdata;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;

  int checks = 0;
  int errors = 0;

  modport_bridge dut (
    .clock     (clock),
    .Hresetn   (Hresetn),
    .Htrans    (Htrans),
    .Hwrite    (Hwrite),
    .Hreadyin  (Hreadyin),
    .Haddr     (Haddr),
    .Hwdata    (Hwdata),
    .Hsize     (Hsize),
    .Hbrust    (Hbrust),
    .Hreadyout (Hreadyout),
    .Hresp     (Hresp),
    .Hrdata    (Hrdata),
    .Prdata    (Prdata),
    .Pselx     (Pselx),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] t, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    Htrans = t;
    Hwrite = w;
    Haddr  = a;
    Hwdata = d;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string tag, input state_e exp);
    check({tag, ".state"}, 32'(dut.state_q), 32'(exp));
  endtask

  task automatic check_apb(input string tag, input logic [2:0] sel, input logic en,
                           input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic rdy);
    check({tag, ".Pselx"},     32'(Pselx),     32'(sel));
    check({tag, ".Penable"},   32'(Penable),   32'(en));
    check({tag, ".Pwrite"},    32'(Pwrite),    32'(wr));
    check({tag, ".Paddr"},     Paddr,          addr);
    check({tag, ".Pwdata"},    Pwdata,         wdata);
    check({tag, ".Hreadyout"}, 32'(Hreadyout), 32'(rdy));
    check({tag, ".Hresp"},     32'(Hresp),     32'(HRESP_OKAY));
  endtask

  initial begin
    Hresetn  = 1'b0;
    Hreadyin = 1'b1;
    Hsize    = 3'd2;
    Hbrust   = 3'd0;
    Prdata   = '0;
    drive(HTRANS_IDLE, 1'b0, 32'h0, 32'h0);

    // Power-on reset
    #12;
    check_state("rst", ST_IDLE);
    check_apb("rst", 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("rst.Hrdata", Hrdata, 32'h0);
    Hresetn = 1'b1;
    step();

    // Single write to slave 0
    drive(HTRANS_NONSEQ, 1'b1, 32'h8000_0010, 32'h0);
    step();
    drive(HTRANS_IDLE, 1'b0, 32'h0, 32'hDEAD_BEEF);
    check_state("wr.wwait", ST_WWAIT);
    check_apb("wr.wwait", 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    check_state("wr.setup", ST_WRITE);
    check_apb("wr.setup", 3'b001, 1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0);
    step();
    check_state("wr.enable", ST_WENABLE);
    check_apb("wr.enable", 3'b001, 1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1);
    step();
    check_state("wr.done", ST_IDLE);
    check("wr.done.Pselx", 32'(Pselx), 32'h0);

    // Single read from slave 1
    Prdata = 32'h1234_5678;
    check("rd.pre.Hreadyout", 32'(Hreadyout), 32'h1);
    drive(HTRANS_NONSEQ, 1'b0, 32'h8400_0004, 32'h0);
    step();
    drive(HTRANS_IDLE, 1'b0, 32'h0, 32'h0);
    check_state("rd.setup", ST_READ);
    check_apb("rd.setup", 3'b010, 1'b0, 1'b0, 32'h8400_0004, 32'hDEAD_BEEF, 1'b0);
    check("rd.setup.Hrdata", Hrdata, 32'h0);
    step();
    check_state("rd.enable", ST_RENABLE);
    check_apb("rd.enable", 3'b010, 1'b1, 1'b0, 32'h8400_0004, 32'hDEAD_BEEF, 1'b1);
    check("rd.enable.Hrdata", Hrdata, 32'h1234_5678);
    step();
    check_state("rd.done", ST_IDLE);
    check("rd.done.Hrdata", Hrdata, 32'h0);

    // Back-to-back writes to slave 2
    drive(HTRANS_NONSEQ, 1'b1, 32'h8800_0000, 32'h0);
    step();
    drive(HTRANS_SEQ, 1'b1, 32'h8800_0004, 32'hAAAA_0001);
    check_state("b2b.wwait", ST_WWAIT);
    step();
    drive(HTRANS_IDLE, 1'b0, 32'h0, 32'hBBBB_0002);
    check_state("b2b.writep", ST_WRITEP);
    check_apb("b2b.writep", 3'b100, 1'b0, 1'b1, 32'h8800_0000, 32'hAAAA_0001, 1'b0);
    step();
    check_state("b2b.wenablep", ST_WENABLEP);
    check_apb("b2b.wenablep", 3'b100, 1'b1, 1'b1, 32'h8800_0000, 32'hAAAA_0001, 1'b1);
    step();
    drive(HTRANS_IDLE, 1'b0, 32'h0, 32'h0);
    check_state("b2b.write", ST_WRITE);
    check_apb("b2b.write", 3'b100, 1'b0, 1'b1, 32'h8800_0004, 32'hBBBB_0002, 1'b0);
    step();
    check_state("b2b.wenable", ST_WENABLE);
    check_apb("b2b.wenable", 3'b100, 1'b1, 1'b1, 32'h8800_0004, 32'hBBBB_0002, 1'b1);
    step();
    check_state("b2b.done", ST_IDLE);

    // Transfers that must be ignored
    drive(HTRANS_NONSEQ, 1'b1, 32'h9000_0000, 32'h0);
    step();
    check_state("inv.range", ST_IDLE);
    check_apb("inv.range", 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    drive(HTRANS_IDLE, 1'b1, 32'h8000_0000, 32'h0);
    step();
    check_state("inv.idle", ST_IDLE);
    check("inv.idle.Pselx", 32'(Pselx), 32'h0);
    drive(HTRANS_BUSY, 1'b0, 32'h8000_0000, 32'h0);
    step();
    check_state("inv.busy", ST_IDLE);
    drive(HTRANS_NONSEQ, 1'b0, 32'h8C00_0000, 32'h0);
    step();
    check_state("inv.above", ST_IDLE);
    drive(HTRANS_NONSEQ, 1'b0, 32'h7FFF_FFFF, 32'h0);
    step();
    check_state("inv.below", ST_IDLE);
    Hreadyin = 1'b0;
    drive(HTRANS_NONSEQ, 1'b0, 32'h8000_0000, 32'h0);
    step();
    check_state("inv.notready", ST_IDLE);
    Hreadyin = 1'b1;

    // Top of the window selects slave 2
    Prdata = 32'h5A5A_A5A5;
    drive(HTRANS_NONSEQ, 1'b0, 32'h8BFF_FFFF, 32'h0);
    step();
    drive(HTRANS_IDLE, 1'b0, 32'h0, 32'h0);
    check_state("edge.read", ST_READ);
    check("edge.read.Pselx", 32'(Pselx), 32'h4);
    check("edge.read.Paddr", Paddr, 32'h8BFF_FFFF);
    step();
    check("edge.renable.Hrdata", Hrdata, 32'h5A5A_A5A5);
    step();

    // Write followed by read
    drive(HTRANS_NONSEQ, 1'b1, 32'h8000_0000, 32'h0);
    step();
    drive(HTRANS_NONSEQ, 1'b0, 32'h8400_0000, 32'hCAFE_F00D);
    step();
    drive(HTRANS_IDLE, 1'b0, 32'h0, 32'h0);
    check_state("mix.writep", ST_WRITEP);
    check_apb("mix.writep", 3'b001, 1'b0, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 1'b0);
    step();
    check_state("mix.wenablep", ST_WENABLEP);
    check_apb("mix.wenablep", 3'b001, 1'b1, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 1'b0);
    Prdata = 32'h0BAD_CAFE;
    step();
    check_state("mix.read", ST_READ);
    check_apb("mix.read", 3'b010, 1'b0, 1'b0, 32'h8400_0000, 32'hCAFE_F00D, 1'b0);
    step();
    check_state("mix.renable", ST_RENABLE);
    check("mix.renable.Hreadyout", 32'(Hreadyout), 32'h1);
    check("mix.renable.Hrdata", Hrdata, 32'h0BAD_CAFE);
    step();

    // Reset asserted in the middle of a write
    drive(HTRANS_NONSEQ, 1'b1, 32'h8000_0010, 32'h0);
    step();
    drive(HTRANS_IDLE, 1'b0, 32'h0, 32'h1111_2222);
    step();
    check("mrst.pre.Pselx", 32'(Pselx), 32'h1);
    #2;
    Hresetn = 1'b0;
    #1;
    check_state("mrst", ST_IDLE);
    check_apb("mrst", 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("mrst.Hrdata", Hrdata, 32'h0);
    step();
    Hresetn = 1'b1;
    step();
    check_state("mrst.after", ST_IDLE);
    check("mrst.after.Pselx", 32'(Pselx), 32'h0);
    step();
    check("mrst.after2.Penable", 32'(Penable), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
